// File: rtl/rob_multi_retire.sv
// rob_multi_retire
//   Reorder buffer with a configurable depth. Dispatch allocates one entry per
//   cycle at the tail. NUM_WB completion ports mark entries done by tag. Up to
//   RETIRE_W of the oldest contiguous done entries retire each cycle, and each
//   retiring entry hands its pd_old back to the rename free list. A branch
//   mispredict squashes every entry younger than the branch. A one-cycle flush
//   pulse then reports the branch tag.
//
// Optional feature: define ROB_STATS_EN to add the saturating counters
//   stat_retired and stat_flushes.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   alloc_valid/ready   dispatch handshake (ready = !full && !mispredict)
//   alloc_pd_new        new destination preg (rename keeps it; not stored here)
//   alloc_pd_old        previous mapping, freed when the entry retires
//   alloc_has_dest      entry writes a register
//   alloc_pc            instruction PC
//   alloc_tag           tag given to the allocating instruction (tail)
//   wb_valid/wb_tag     per-port completion strobe and tag
//   br_mispredict/tag   mispredict report from the branch unit
//   mispredict(_tag)    registered flush pulse and its branch tag
//   retire_*            per-slot retire group; valid bits contiguous from bit 0
//   head, count         oldest tag, number of occupied entries
//   full, empty         count==DEPTH, count==0
//   stat_retired        (ROB_STATS_EN) total retired instructions, saturating
//   stat_flushes        (ROB_STATS_EN) total flush pulses, saturating
module rob_multi_retire #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned TAG_W    = $clog2(DEPTH),
  parameter int unsigned PREG_W   = 7,
  parameter int unsigned NUM_WB   = 4,
  parameter int unsigned RETIRE_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [PREG_W-1:0]          alloc_pd_new,
  input  logic [PREG_W-1:0]          alloc_pd_old,
  input  logic                       alloc_has_dest,
  input  logic [31:0]                alloc_pc,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic                       br_mispredict,
  input  logic [TAG_W-1:0]           br_tag,
  output logic                       mispredict,
  output logic [TAG_W-1:0]           mispredict_tag,
  output logic [RETIRE_W-1:0]        retire_valid,
  output logic [RETIRE_W-1:0]        retire_has_dest,
  output logic [RETIRE_W*PREG_W-1:0] retire_pd_old,
  output logic [RETIRE_W*32-1:0]     retire_pc,
  output logic [TAG_W-1:0]           head,
  output logic [TAG_W:0]             count,
  output logic                       full,
  output logic                       empty
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]                stat_retired,
  output logic [15:0]                stat_flushes
`endif
);

  localparam int unsigned CNT_W = TAG_W + 1;

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic              mispredict_q, mispredict_d;
  logic [TAG_W-1:0]  mis_tag_q, mis_tag_d;

  logic [PREG_W-1:0] pd_old_q   [DEPTH];
  logic              has_dest_q [DEPTH];
  logic [31:0]       pc_q       [DEPTH];

  logic              alloc_fire;
  logic              flush_accept;
  logic              br_live;
  logic [TAG_W-1:0]  br_age;
  logic [TAG_W-1:0]  mis_age;
  logic [RETIRE_W-1:0] ret_valid;
  logic [CNT_W-1:0]  n_ret;
  logic              run;
  logic [TAG_W-1:0]  slot_tag [RETIRE_W];
  logic [TAG_W-1:0]  wb_tag_a [NUM_WB];

  // Rename keeps the new mapping itself. The ROB needs only pd_old.
  logic unused_pd_new;
  assign unused_pd_new = ^alloc_pd_new;

  // Age relative to head. The modulo-DEPTH wrap comes from the TAG_W-bit subtraction.
  function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] t,
                                               input logic [TAG_W-1:0] h);
    return t - h;
  endfunction

  function automatic logic is_live(input logic [TAG_W-1:0] t,
                                   input logic [TAG_W-1:0] h,
                                   input logic [CNT_W-1:0] c);
    return {1'b0, age_of(t, h)} < c;
  endfunction

  for (genvar w = 0; w < NUM_WB; w++) begin : g_wb
    assign wb_tag_a[w] = wb_tag[w*TAG_W +: TAG_W];
  end

  // Allocation decision uses registered count only; a retire in the same
  // cycle does not free a slot for the allocating instruction.
  assign alloc_ready = (count_q != CNT_W'(DEPTH)) && !mispredict_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign br_age  = age_of(br_tag, head_q);
  assign mis_age = age_of(mis_tag_q, head_q);
  assign br_live = {1'b0, br_age} < count_q;

  // While a flush pulse is outstanding, only a strictly older branch may
  // replace the one being recovered.
  assign flush_accept = br_mispredict && br_live &&
                        (!mispredict_q || (br_age < mis_age));

  // Retire group: contiguous done entries from head. When a flush is being
  // captured this cycle, the group stops at the branch itself.
  always_comb begin
    ret_valid = '0;
    n_ret     = '0;
    run       = 1'b1;
    for (int unsigned k = 0; k < RETIRE_W; k++) begin
      if (run && (CNT_W'(k) < count_q) && done_q[slot_tag[k]] &&
          (!flush_accept || (TAG_W'(k) <= br_age))) begin
        ret_valid[k] = 1'b1;
        n_ret        = n_ret + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next-state logic. A squash overrides the normal tail and count update.
  // An allocation in the capture cycle is younger than the branch, so the
  // squash discards it.
  always_comb begin
    head_d       = head_q + TAG_W'(n_ret);
    tail_d       = tail_q;
    count_d      = count_q;
    done_d       = done_q;
    mispredict_d = flush_accept;
    mis_tag_d    = mis_tag_q;

    for (int unsigned w = 0; w < NUM_WB; w++) begin
      if (wb_valid[w] && is_live(wb_tag_a[w], head_q, count_q)) begin
        done_d[wb_tag_a[w]] = 1'b1;
      end
    end

    if (alloc_fire) begin
      done_d[tail_q] = 1'b0;
    end

    if (flush_accept) begin
      tail_d    = br_tag + TAG_W'(1);
      count_d   = {1'b0, br_age} + CNT_W'(1) - n_ret;
      mis_tag_d = br_tag;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (is_live(TAG_W'(i), head_q, count_q) &&
            (age_of(TAG_W'(i), head_q) > br_age)) begin
          done_d[i] = 1'b0;
        end
      end
    end else begin
      tail_d  = tail_q + TAG_W'(alloc_fire);
      count_d = count_q + CNT_W'(alloc_fire) - n_ret;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      done_q       <= '0;
      mispredict_q <= 1'b0;
      mis_tag_q    <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      done_q       <= done_d;
      mispredict_q <= mispredict_d;
      mis_tag_q    <= mis_tag_d;
    end
  end

  // Payload storage. Entries are only read while live, so no reset is needed.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pd_old_q[tail_q]   <= alloc_pd_old;
      has_dest_q[tail_q] <= alloc_has_dest;
      pc_q[tail_q]       <= alloc_pc;
    end
  end

  for (genvar k = 0; k < RETIRE_W; k++) begin : g_slot
    assign slot_tag[k]                           = head_q + TAG_W'(k);
    assign retire_pd_old[k*PREG_W +: PREG_W]     = pd_old_q[slot_tag[k]];
    assign retire_has_dest[k]                    = has_dest_q[slot_tag[k]];
    assign retire_pc[k*32 +: 32]                 = pc_q[slot_tag[k]];
  end

  assign retire_valid   = ret_valid;
  assign alloc_tag      = tail_q;
  assign head           = head_q;
  assign count          = count_q;
  assign full           = (count_q == CNT_W'(DEPTH));
  assign empty          = (count_q == '0);
  assign mispredict     = mispredict_q;
  assign mispredict_tag = mis_tag_q;

`ifdef ROB_STATS_EN
  logic [31:0] stat_retired_q;
  logic [15:0] stat_flushes_q;
  logic [32:0] ret_sum;

  assign ret_sum = {1'b0, stat_retired_q} + 33'(n_ret);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_retired_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      stat_retired_q <= ret_sum[32] ? '1 : ret_sum[31:0];
      if (mispredict_q && (stat_flushes_q != '1)) begin
        stat_flushes_q <= stat_flushes_q + 16'd1;
      end
    end
  end

  assign stat_retired = stat_retired_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_rob_multi_retire.sv
// Testbench for rob_multi_retire. A queue-based model of the buffer's
// contents tracks the expected retire group, count, head, tail and flush state.
module tb_rob_multi_retire;
  localparam int DEPTH    = 32;
  localparam int TAG_W    = 5;
  localparam int PREG_W   = 7;
  localparam int NUM_WB   = 4;
  localparam int RETIRE_W = 2;

  logic                       clk;
  logic                       reset;
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [PREG_W-1:0]          alloc_pd_new;
  logic [PREG_W-1:0]          alloc_pd_old;
  logic                       alloc_has_dest;
  logic [31:0]                alloc_pc;
  logic [TAG_W-1:0]           alloc_tag;
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*TAG_W-1:0]    wb_tag;
  logic                       br_mispredict;
  logic [TAG_W-1:0]           br_tag;
  logic                       mispredict;
  logic [TAG_W-1:0]           mispredict_tag;
  logic [RETIRE_W-1:0]        retire_valid;
  logic [RETIRE_W-1:0]        retire_has_dest;
  logic [RETIRE_W*PREG_W-1:0] retire_pd_old;
  logic [RETIRE_W*32-1:0]     retire_pc;
  logic [TAG_W-1:0]           head;
  logic [TAG_W:0]             count;
  logic                       full;
  logic                       empty;
`ifdef ROB_STATS_EN
  logic [31:0]                stat_retired;
  logic [15:0]                stat_flushes;
`endif

  rob_multi_retire #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W),
    .NUM_WB(NUM_WB), .RETIRE_W(RETIRE_W)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
    .alloc_has_dest(alloc_has_dest), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .br_mispredict(br_mispredict), .br_tag(br_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .retire_valid(retire_valid), .retire_has_dest(retire_has_dest),
    .retire_pd_old(retire_pd_old), .retire_pc(retire_pc),
    .head(head), .count(count), .full(full), .empty(empty)
`ifdef ROB_STATS_EN
    , .stat_retired(stat_retired), .stat_flushes(stat_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          pd;
    bit          hd;
    logic [31:0] pc;
    bit          done;
  } ent_t;

  ent_t mq[$];
  int   m_head, m_tail, m_mis_tag;
  bit   m_mis;

  int   checks, failures;

  bit          e_ready, e_accept;
  int          e_nret;
  logic [1:0]  e_rv;
  int          e_pd [RETIRE_W];
  bit          e_hd [RETIRE_W];
  logic [31:0] e_pc [RETIRE_W];

  function automatic int find_tag(int t);
    foreach (mq[i]) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  // Predict this cycle's outputs from the model and the inputs now applied.
  task automatic sample();
    int bidx, midx;
    @(negedge clk);
    e_ready  = (mq.size() < DEPTH) && !m_mis;
    bidx     = br_mispredict ? find_tag(int'(br_tag)) : -1;
    midx     = m_mis ? find_tag(m_mis_tag) : -1;
    e_accept = br_mispredict && (bidx >= 0) && (!m_mis || midx < 0 || bidx < midx);
    e_nret   = 0;
    e_rv     = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (k < mq.size() && mq[k].done && (!e_accept || k <= bidx)) begin
        e_rv[k] = 1'b1;
        e_pd[k] = mq[k].pd;
        e_hd[k] = mq[k].hd;
        e_pc[k] = mq[k].pc;
        e_nret++;
      end else begin
        break;
      end
    end
  endtask

  // Apply the clock edge to the model, then release one-shot inputs.
  task automatic advance();
    int idx;
    ent_t e;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_head = 0; m_tail = 0; m_mis = 0; m_mis_tag = 0;
    end else begin
      for (int w = 0; w < NUM_WB; w++) begin
        if (wb_valid[w]) begin
          idx = find_tag(int'(wb_tag[w*TAG_W +: TAG_W]));
          if (idx >= 0) mq[idx].done = 1'b1;
        end
      end
      if (alloc_valid && e_ready) begin
        e.tag = m_tail; e.pd = int'(alloc_pd_old); e.hd = alloc_has_dest;
        e.pc = alloc_pc; e.done = 1'b0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
      for (int k = 0; k < e_nret; k++) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (e_accept) begin
        idx = find_tag(int'(br_tag));
        if (idx < 0) mq.delete();
        else while (mq.size() > idx + 1) void'(mq.pop_back());
        m_tail    = (int'(br_tag) + 1) % DEPTH;
        m_mis_tag = int'(br_tag);
      end
      m_mis = e_accept;
    end
    #1;
    alloc_valid   = 1'b0;
    wb_valid      = '0;
    wb_tag        = '0;
    br_mispredict = 1'b0;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic set_wb(int p, int t);
    wb_valid[p]            = 1'b1;
    wb_tag[p*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  task automatic do_alloc(int pd, int pc);
    alloc_valid    = 1'b1;
    alloc_pd_old   = PREG_W'(pd);
    alloc_pd_new   = PREG_W'(pd + 40);
    alloc_has_dest = 1'b1;
    alloc_pc       = 32'(pc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", mispredict); end
    checks++; if (mispredict_tag !== 5'd0) begin failures++; $display("FAIL reset_mistag got=%0d exp=0", mispredict_tag); end
    checks++; if (retire_valid !== 2'b00) begin failures++; $display("FAIL reset_rv got=%b exp=00", retire_valid); end
    checks++; if (head !== 5'd0) begin failures++; $display("FAIL reset_head got=%0d exp=0", head); end
    checks++; if (alloc_tag !== 5'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", alloc_tag); end
    advance();
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_alloc(10 + i, 'h1000 + 4 * i);
      sample();
      checks++; if (alloc_tag !== 5'(i)) begin failures++; $display("FAIL basic_tag got=%0d exp=%0d", alloc_tag, i); end
      advance();
    end
    set_wb(0, 1);
    sample();
    checks++; if (count !== 6'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
    checks++; if (retire_valid !== 2'b00) begin failures++; $display("FAIL basic_rv_wait got=%b exp=00", retire_valid); end
    advance();
    set_wb(0, 0);
    sample();
    checks++; if (retire_valid !== 2'b00) begin failures++; $display("FAIL basic_rv_t1only got=%b exp=00", retire_valid); end
    advance();
    sample();
    checks++; if (retire_valid !== 2'b11) begin failures++; $display("FAIL basic_rv_pair got=%b exp=11", retire_valid); end
    checks++; if (retire_pd_old !== {7'd11, 7'd10}) begin failures++; $display("FAIL basic_pd_pair got=%h exp=%h", retire_pd_old, {7'd11, 7'd10}); end
    checks++; if (retire_pc[31:0] !== 32'h1000) begin failures++; $display("FAIL basic_pc0 got=%h exp=1000", retire_pc[31:0]); end
    advance();
    set_wb(2, 2);
    sample();
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    advance();
    sample();
    checks++; if (retire_valid !== 2'b01) begin failures++; $display("FAIL basic_rv_t2 got=%b exp=01", retire_valid); end
    checks++; if (retire_pd_old[6:0] !== 7'd12) begin failures++; $display("FAIL basic_pd_t2 got=%0d exp=12", retire_pd_old[6:0]); end
    advance();
    sample();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    advance();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_alloc(i, 'h2000 + 4 * i);
      step();
    end
    do_alloc(99, 'h3000);
    set_wb(0, 0);
    sample();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_full got=%b exp=1", full); end
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", alloc_ready); end
    checks++; if (count !== 6'd32) begin failures++; $display("FAIL full_count got=%0d exp=32", count); end
    advance();
    sample();
    checks++; if (retire_valid !== 2'b01) begin failures++; $display("FAIL full_rv got=%b exp=01", retire_valid); end
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_nobypass got=%b exp=0", alloc_ready); end
    advance();
    sample();
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after got=%b exp=1", alloc_ready); end
    checks++; if (alloc_tag !== 5'd0) begin failures++; $display("FAIL full_tag_after got=%0d exp=0", alloc_tag); end
    checks++; if (count !== 6'd31) begin failures++; $display("FAIL full_count_after got=%0d exp=31", count); end
    advance();
  endtask

  task automatic test_stream();
    int t;
    for (int cyc = 0; cyc < 400; cyc++) begin
      alloc_valid    = ($urandom_range(0, 99) < 65);
      alloc_pd_old   = PREG_W'($urandom);
      alloc_pd_new   = PREG_W'($urandom);
      alloc_has_dest = 1'($urandom_range(0, 1));
      alloc_pc       = $urandom;
      for (int w = 0; w < NUM_WB; w++) begin
        if ($urandom_range(0, 99) < 40) begin
          if (mq.size() > 0 && $urandom_range(0, 9) < 8)
            t = mq[$urandom_range(0, mq.size() - 1)].tag;
          else
            t = $urandom_range(0, DEPTH - 1);
          set_wb(w, t);
        end
      end
      if (mq.size() > 0 && $urandom_range(0, 99) < 5) begin
        br_mispredict = 1'b1;
        if ($urandom_range(0, 9) < 8) br_tag = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
        else br_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      end
      sample();
      checks++; if (retire_valid !== e_rv) begin failures++; $display("FAIL stream_rv cyc=%0d got=%b exp=%b", cyc, retire_valid, e_rv); end
      checks++; if (count !== 6'(mq.size())) begin failures++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); end
      checks++; if (count > 6'd32) begin failures++; $display("FAIL stream_overflow cyc=%0d got=%0d exp<=32", cyc, count); end
      checks++; if (head !== 5'(m_head)) begin failures++; $display("FAIL stream_head cyc=%0d got=%0d exp=%0d", cyc, head, m_head); end
      checks++; if (alloc_tag !== 5'(m_tail)) begin failures++; $display("FAIL stream_tag cyc=%0d got=%0d exp=%0d", cyc, alloc_tag, m_tail); end
      checks++; if (alloc_ready !== e_ready) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, alloc_ready, e_ready); end
      checks++; if (mispredict !== m_mis) begin failures++; $display("FAIL stream_mis cyc=%0d got=%b exp=%b", cyc, mispredict, m_mis); end
      checks++; if (mispredict_tag !== 5'(m_mis_tag)) begin failures++; $display("FAIL stream_mistag cyc=%0d got=%0d exp=%0d", cyc, mispredict_tag, m_mis_tag); end
      checks++; if (full !== (mq.size() == DEPTH)) begin failures++; $display("FAIL stream_full cyc=%0d got=%b", cyc, full); end
      checks++; if (empty !== (mq.size() == 0)) begin failures++; $display("FAIL stream_empty cyc=%0d got=%b", cyc, empty); end
      for (int k = 0; k < RETIRE_W; k++) begin
        if (e_rv[k]) begin
          checks++; if (retire_pd_old[k*PREG_W +: PREG_W] !== 7'(e_pd[k])) begin failures++; $display("FAIL stream_pd cyc=%0d slot=%0d got=%0d exp=%0d", cyc, k, retire_pd_old[k*PREG_W +: PREG_W], e_pd[k]); end
          checks++; if (retire_has_dest[k] !== e_hd[k]) begin failures++; $display("FAIL stream_hd cyc=%0d slot=%0d got=%b exp=%b", cyc, k, retire_has_dest[k], e_hd[k]); end
          checks++; if (retire_pc[k*32 +: 32] !== e_pc[k]) begin failures++; $display("FAIL stream_pc cyc=%0d slot=%0d got=%h exp=%h", cyc, k, retire_pc[k*32 +: 32], e_pc[k]); end
        end
      end
      advance();
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_alloc(i, 'h4000 + 4 * i);
      step();
    end
    set_wb(0, 0); set_wb(1, 1);
    step();
    sample();
    checks++; if (retire_valid !== 2'b11) begin failures++; $display("FAIL mis_pre_rv got=%b exp=11", retire_valid); end
    advance();
    br_mispredict = 1'b1; br_tag = 5'd5;
    sample();
    checks++; if (head !== 5'd2) begin failures++; $display("FAIL mis_head got=%0d exp=2", head); end
    checks++; if (alloc_tag !== 5'd10) begin failures++; $display("FAIL mis_tail got=%0d exp=10", alloc_tag); end
    checks++; if (count !== 6'd8) begin failures++; $display("FAIL mis_count_pre got=%0d exp=8", count); end
    advance();
    set_wb(0, 7);
    sample();
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", mispredict); end
    checks++; if (mispredict_tag !== 5'd5) begin failures++; $display("FAIL mis_tag got=%0d exp=5", mispredict_tag); end
    checks++; if (alloc_tag !== 5'd6) begin failures++; $display("FAIL mis_newtail got=%0d exp=6", alloc_tag); end
    checks++; if (count !== 6'd4) begin failures++; $display("FAIL mis_count got=%0d exp=4", count); end
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL mis_block got=%b exp=0", alloc_ready); end
    advance();
    do_alloc(50, 'h5000);
    sample();
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL mis_onecycle got=%b exp=0", mispredict); end
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL mis_unblock got=%b exp=1", alloc_ready); end
    advance();
    do_alloc(51, 'h5004);
    sample();
    checks++; if (alloc_tag !== 5'd7) begin failures++; $display("FAIL mis_tag7 got=%0d exp=7", alloc_tag); end
    advance();
    set_wb(0, 2); set_wb(1, 3); set_wb(2, 4); set_wb(3, 5);
    step();
    step();
    step();
    sample();
    checks++; if (retire_valid !== 2'b00) begin failures++; $display("FAIL mis_drain_rv got=%b exp=00", retire_valid); end
    checks++; if (head !== 5'd6) begin failures++; $display("FAIL mis_drain_head got=%0d exp=6", head); end
    checks++; if (count !== 6'd2) begin failures++; $display("FAIL mis_drain_count got=%0d exp=2", count); end
    advance();
    set_wb(0, 6);
    step();
    sample();
    checks++; if (retire_valid !== 2'b01) begin failures++; $display("FAIL mis_stale_wb got=%b exp=01", retire_valid); end
    checks++; if (retire_pd_old[6:0] !== 7'd50) begin failures++; $display("FAIL mis_pd6 got=%0d exp=50", retire_pd_old[6:0]); end
    advance();
  endtask

  task automatic test_multi_wb();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_alloc(20 + i, 'h6000 + 4 * i);
      step();
    end
    set_wb(0, 3); set_wb(1, 3); set_wb(2, 4); set_wb(3, 9);
    step();
    sample();
    checks++; if (retire_valid !== 2'b00) begin failures++; $display("FAIL mwb_rv0 got=%b exp=00", retire_valid); end
    checks++; if (count !== 6'd5) begin failures++; $display("FAIL mwb_count got=%0d exp=5", count); end
    checks++; if (alloc_tag !== 5'd5) begin failures++; $display("FAIL mwb_tail got=%0d exp=5", alloc_tag); end
    advance();
    set_wb(0, 0); set_wb(1, 1); set_wb(2, 2);
    step();
    step();
    sample();
    checks++; if (retire_valid !== 2'b11) begin failures++; $display("FAIL mwb_rv34 got=%b exp=11", retire_valid); end
    checks++; if (retire_pd_old !== {7'd23, 7'd22}) begin failures++; $display("FAIL mwb_pd got=%h exp=%h", retire_pd_old, {7'd23, 7'd22}); end
    advance();
    sample();
    checks++; if (retire_valid !== 2'b01) begin failures++; $display("FAIL mwb_rv4 got=%b exp=01", retire_valid); end
    advance();
    sample();
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL mwb_empty got=%0d exp=0", count); end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_alloc(i, 'h7000 + 4 * i);
      step();
    end
    br_mispredict = 1'b1; br_tag = 5'd11;
    step();
    reset = 1'b1;
    sample();
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL rmid_pulse got=%b exp=1", mispredict); end
    checks++; if (count !== 6'd12) begin failures++; $display("FAIL rmid_count_pre got=%0d exp=12", count); end
    advance();
    reset = 1'b0;
    sample();
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", count); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL rmid_mis got=%b exp=0", mispredict); end
    checks++; if (alloc_tag !== 5'd0) begin failures++; $display("FAIL rmid_tail got=%0d exp=0", alloc_tag); end
`ifdef ROB_STATS_EN
    checks++; if (stat_flushes !== 16'd0) begin failures++; $display("FAIL rmid_stat_fl got=%0d exp=0", stat_flushes); end
    checks++; if (stat_retired !== 32'd0) begin failures++; $display("FAIL rmid_stat_rt got=%0d exp=0", stat_retired); end
`endif
    advance();
    for (int i = 0; i < 6; i++) begin
      do_alloc(30 + i, 'h8000 + 4 * i);
      step();
    end
    set_wb(0, 0); set_wb(1, 1); set_wb(2, 2); set_wb(3, 3);
    step();
    set_wb(0, 4);
    step();
    step();
    step();
    step();
    br_mispredict = 1'b1; br_tag = 5'd5;
    step();
    step();
    step();
    sample();
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL stats_count got=%0d exp=1", count); end
    checks++; if (head !== 5'd5) begin failures++; $display("FAIL stats_head got=%0d exp=5", head); end
`ifdef ROB_STATS_EN
    checks++; if (stat_retired !== 32'd5) begin failures++; $display("FAIL stats_retired got=%0d exp=5", stat_retired); end
    checks++; if (stat_flushes !== 16'd1) begin failures++; $display("FAIL stats_flushes got=%0d exp=1", stat_flushes); end
`endif
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; alloc_valid = 1'b0; alloc_pd_new = '0; alloc_pd_old = '0;
    alloc_has_dest = 1'b0; alloc_pc = '0; wb_valid = '0; wb_tag = '0;
    br_mispredict = 1'b0; br_tag = '0;
    m_head = 0; m_tail = 0; m_mis = 0; m_mis_tag = 0;
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_mispredict();
    test_multi_wb();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
